// File: rtl/rcvr_arbiter.sv
// Round-robin read scheduler for a bank of serial frame receivers.
// Captures one byte per grant and hands it downstream on valid/accept.
module rcvr_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         chan_enable,
    input  logic [N-1:0]         rx_ready,
    input  logic [N-1:0]         rx_overrun,
    input  logic [N*DATA_W-1:0]  rx_data,
    output logic [N-1:0]         rx_reading,
    output logic                 out_valid,
    input  logic                 out_accept,
    output logic [DATA_W-1:0]    out_data,
    output logic [$clog2(N)-1:0] out_chan,
    output logic                 out_ovr,
    output logic [CNT_W-1:0]     ovr_count,
    input  logic                 ovr_clear
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N-1:0]      rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PW-1:0]     chan_q, chan_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N-1:0]      req;
    logic              found;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     idx;
    logic [PW-1:0]     ptr_next;

    assign req = rx_ready & chan_enable;

    // First requester at or above rr_ptr, wrapping past N-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(rr_ptr_q) + i) % N);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign ptr_next = PW'((int'(gnt_idx) + 1) % N);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        rd_d     = '0;
        data_d   = data_q;
        chan_d   = chan_q;
        ovr_d    = ovr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    chan_d       = gnt_idx;
                    data_d       = rx_data[int'(gnt_idx)*DATA_W +: DATA_W];
                    ovr_d        = rx_overrun[gnt_idx];
                    rr_ptr_d     = ptr_next;
                    rd_d[gnt_idx] = 1'b1;
                    state_d      = READ;
                    if (rx_overrun[gnt_idx] && cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            READ: begin
                state_d = VALID;
            end
            VALID: begin
                if (out_accept) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A clear wins over an increment in the same cycle.
        if (ovr_clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            chan_q   <= '0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rx_reading = rd_q;
    assign out_valid  = (state_q == VALID);
    assign out_data   = data_q;
    assign out_chan   = chan_q;
    assign out_ovr    = ovr_q;
    assign ovr_count  = cnt_q;

endmodule

// File: doc/rcvr_arbiter.md
Name: rcvr_arbiter

Overview:
Round-robin read scheduler for a bank of N serial frame receivers. Each receiver presents ready/overrun/data_out.
- The block selects one ready receiver.
- It pulses that receiver's reading line for one cycle and captures its byte and overrun flag.
- It presents the result on a single valid/accept output port to the downstream consumer.
- It keeps a saturating count of overrun events across all channels.

Parameters:
N, 4, number of receiver channels (2..8)
DATA_W, 8, byte width per channel
CNT_W, 8, width of overrun event counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
chan_enable  input  N  per-channel enable mask; a disabled channel is never granted
rx_ready  input  N  ready flag from each receiver
rx_overrun  input  N  overrun flag from each receiver
rx_data  input  N*DATA_W  receiver data_out buses, channel i at bits [i*DATA_W +: DATA_W]
rx_reading  output  N  one-hot read strobe back to receivers, registered
out_valid  output  1  captured byte available
out_accept  input  1  downstream takes byte when out_valid && out_accept
out_data  output  DATA_W  captured byte
out_chan  output  $clog2(N)  index of source channel
out_ovr  output  1  overrun flag captured with the byte
ovr_count  output  CNT_W  saturating count of captured bytes with overrun set
ovr_clear  input  1  synchronous clear of ovr_count

Behaviour:
- Reset (reset low, asynchronous), all held until reset returns high:
  - state=IDLE, rr_ptr=0, rx_reading=0, out_valid=0, out_data=0, out_chan=0, out_ovr=0, ovr_count=0.
  - Reset asserted mid-transfer aborts it; the pending byte is discarded with no strobe.
- Request vector req = rx_ready & chan_enable.
- Grant selection is round-robin: first set bit of req searching upward from rr_ptr, wrapping from N-1 to 0.
- States:
  - IDLE: if req!=0 at a clock edge:
    - latch winner index g into out_chan.
    - latch rx_data slice g into out_data and rx_overrun[g] into out_out_ovr.
    - rr_ptr <= (g+1) mod N; go to READ.
    - If req==0, stay in IDLE.
  - READ: rx_reading[g]=1 for exactly this one cycle (one-hot, all other bits 0); go to VALID.
  - VALID: out_valid=1. out_data/out_chan/out_ovr held stable while out_valid is high. On out_accept=1, go to IDLE; out_valid drops the next cycle.
- Latency: req seen at edge k -> rx_reading high in cycle k+1 -> out_valid high from cycle k+2.
- Minimum turnaround is 3 cycles per byte with out_accept tied high.
- Never more than one rx_reading bit high; rx_reading=0 in IDLE and VALID.
- Data is captured in IDLE, before the strobe, so a byte arriving in the strobe cycle is not lost. The receiver re-asserts ready, and the channel is re-arbitrated normally.
- rx_ready deasserting while in READ/VALID has no effect; the captured byte stands.
- chan_enable changes take effect at the next IDLE evaluation only.
- ovr_count:
  - Increments by 1 on the IDLE->READ edge when the captured overrun bit is 1.
  - Saturates at 2^CNT_W-1.
  - ovr_clear=1 sets it to 0; clear has priority over a simultaneous increment.
- Disabled channels with ready set are ignored indefinitely. There is no timeout.

Test Plan:
- Single channel: N=4, rx_data ch2=8'hA5, rx_ready=4'b0100, out_accept=1 -> rx_reading=4'b0100 for one cycle at k+1; out_valid at k+2 with out_data=8'hA5, out_chan=2, out_ovr=0; rr_ptr=3.
- Round-robin fairness: rx_ready=4'b1111 held, each receiver dropping ready one cycle after its strobe and re-asserting two cycles later -> grant order 0,1,2,3,0,1; no channel granted twice before others.
- Backpressure: out_accept=0 for 10 cycles after out_valid with ch1=8'h3C -> out_valid, out_data=8'h3C, out_chan=1 stable all 10 cycles; no further rx_reading pulses; one cycle after out_accept=1, out_valid=0.
- Overrun and saturation: CNT_W=2, four grants with rx_overrun set -> out_ovr=1 each time; ovr_count 1,2,3,3. Then ovr_clear=1 coinciding with a fifth overrun capture -> ovr_count=0.
- Masking: rx_ready=4'b0011, chan_enable=4'b1110 -> only ch1 granted; ch0 never strobed while masked. Set chan_enable=4'b1111 -> ch0 granted on the next IDLE after wrap.
- Async reset mid-transfer: drop reset during READ -> rx_reading=0 and out_valid=0 immediately, ovr_count=0. After release with rx_ready=4'b1000, first grant is ch3 searched from rr_ptr=0.
